// File: rtl/cluster_noc_txn_throttle.sv
// Per-port outstanding-transaction throttle in front of a cluster NoC demux.
// Gates AW/AR beats when a target port is saturated, draining, or mis-addressed.

package cluster_noc_txn_throttle_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

module cluster_noc_txn_throttle
    import cluster_noc_txn_throttle_pkg::*;
#(
    parameter int NumClusters = 4,
    parameter int MaxTxns     = 8,
    localparam int SelWidth   = idx_width(NumClusters + 1),
    localparam int CntWidth   = $clog2(MaxTxns + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                aw_valid_i,
    output logic                aw_ready_o,
    input  logic [SelWidth-1:0] aw_sel_i,
    output logic                aw_valid_o,
    input  logic                aw_ready_i,
    input  logic                ar_valid_i,
    output logic                ar_ready_o,
    input  logic [SelWidth-1:0] ar_sel_i,
    output logic                ar_valid_o,
    input  logic                ar_ready_i,
    input  logic                b_done_i,
    input  logic [SelWidth-1:0] b_sel_i,
    input  logic                r_done_i,
    input  logic [SelWidth-1:0] r_sel_i,
    input  logic                drain_req_i,
    output logic                drain_ack_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam int NumPorts = NumClusters + 1;
    localparam logic [SelWidth-1:0] LastSel = SelWidth'(NumClusters);
    localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MaxTxns);
    localparam logic [CntWidth-1:0] CntZero = {CntWidth{1'b0}};
    localparam logic [CntWidth-1:0] CntOne  = {{(CntWidth-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_IDLE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CntWidth-1:0] wcnt_q [NumPorts];
    logic [CntWidth-1:0] wcnt_d [NumPorts];
    logic [CntWidth-1:0] rcnt_q [NumPorts];
    logic [CntWidth-1:0] rcnt_d [NumPorts];
    logic                w_inc_s [NumPorts];
    logic                w_dec_s [NumPorts];
    logic                r_inc_s [NumPorts];
    logic                r_dec_s [NumPorts];
    logic                drain_ack_q, drain_ack_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic aw_oob_s, ar_oob_s, b_oob_s, r_oob_s;
    logic aw_full_s, ar_full_s;
    logic aw_block_s, ar_block_s;
    logic aw_issue_s, ar_issue_s;
    logic uflow_s, any_nz_s, sel_err_s;

    // A completion on an empty counter saturates at zero; simultaneous issue
    // and completion on the same port cancel out.
    function automatic logic [CntWidth-1:0] next_count(
        input logic [CntWidth-1:0] cnt,
        input logic                inc,
        input logic                dec
    );
        logic [CntWidth-1:0] res;
        case ({inc, dec})
            2'b10:   res = cnt + CntOne;
            2'b01:   res = (cnt == CntZero) ? CntZero : (cnt - CntOne);
            default: res = cnt;
        endcase
        return res;
    endfunction

    // Address-channel gating: saturated port, not running, or bad select.
    always_comb begin
        aw_oob_s  = (aw_sel_i > LastSel);
        ar_oob_s  = (ar_sel_i > LastSel);
        b_oob_s   = (b_sel_i > LastSel);
        r_oob_s   = (r_sel_i > LastSel);
        aw_full_s = 1'b0;
        ar_full_s = 1'b0;
        for (int p = 0; p < NumPorts; p++) begin
            aw_full_s = aw_full_s | ((aw_sel_i == SelWidth'(p)) & (wcnt_q[p] == CntMax));
            ar_full_s = ar_full_s | ((ar_sel_i == SelWidth'(p)) & (rcnt_q[p] == CntMax));
        end
        aw_block_s = aw_full_s | (state_q != ST_RUN) | aw_oob_s;
        ar_block_s = ar_full_s | (state_q != ST_RUN) | ar_oob_s;
    end

    assign aw_valid_o = aw_valid_i & ~aw_block_s;
    assign aw_ready_o = aw_ready_i & ~aw_block_s;
    assign ar_valid_o = ar_valid_i & ~ar_block_s;
    assign ar_ready_o = ar_ready_i & ~ar_block_s;
    assign aw_issue_s = aw_valid_o & aw_ready_i;
    assign ar_issue_s = ar_valid_o & ar_ready_i;

    // Next counter values, underflow detection and sticky error.
    always_comb begin
        uflow_s  = 1'b0;
        any_nz_s = 1'b0;
        for (int p = 0; p < NumPorts; p++) begin
            w_inc_s[p] = aw_issue_s & (aw_sel_i == SelWidth'(p));
            w_dec_s[p] = b_done_i & ~b_oob_s & (b_sel_i == SelWidth'(p));
            r_inc_s[p] = ar_issue_s & (ar_sel_i == SelWidth'(p));
            r_dec_s[p] = r_done_i & ~r_oob_s & (r_sel_i == SelWidth'(p));
            wcnt_d[p]  = next_count(wcnt_q[p], w_inc_s[p], w_dec_s[p]);
            rcnt_d[p]  = next_count(rcnt_q[p], r_inc_s[p], r_dec_s[p]);
            uflow_s    = uflow_s
                       | (w_dec_s[p] & ~w_inc_s[p] & (wcnt_q[p] == CntZero))
                       | (r_dec_s[p] & ~r_inc_s[p] & (rcnt_q[p] == CntZero));
            any_nz_s   = any_nz_s | (wcnt_d[p] != CntZero) | (rcnt_d[p] != CntZero);
        end
        sel_err_s = (aw_valid_i & aw_oob_s) | (ar_valid_i & ar_oob_s)
                  | (b_done_i & b_oob_s) | (r_done_i & r_oob_s);
        err_d     = err_q | uflow_s | sel_err_s;
        busy_d    = any_nz_s;
    end

    // Drain FSM; emptiness is judged on next-cycle counts so same-cycle
    // completions can finish the drain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (drain_req_i) state_d = ST_DRAIN;
                else             state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (!drain_req_i)   state_d = ST_RUN;
                else if (!any_nz_s) state_d = ST_IDLE;
                else                state_d = ST_DRAIN;
            end
            ST_IDLE: begin
                if (!drain_req_i) state_d = ST_RUN;
                else              state_d = ST_IDLE;
            end
            default: state_d = ST_RUN;
        endcase
        drain_ack_d = (state_d == ST_IDLE);
    end

    // State, counter and status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < NumPorts; p++) begin
                wcnt_q[p] <= CntZero;
                rcnt_q[p] <= CntZero;
            end
            state_q     <= ST_RUN;
            drain_ack_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                wcnt_q[p] <= wcnt_d[p];
                rcnt_q[p] <= rcnt_d[p];
            end
            state_q     <= state_d;
            drain_ack_q <= drain_ack_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign drain_ack_o = drain_ack_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_cluster_noc_txn_throttle.sv
// Directed bench for cluster_noc_txn_throttle with MaxTxns=2, NumClusters=4.
module tb_cluster_noc_txn_throttle;

    localparam int NC = 4;
    localparam int MT = 2;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          aw_valid_i = 1'b0, aw_ready_i = 1'b0;
    logic [SW-1:0] aw_sel_i = 3'd0;
    logic          ar_valid_i = 1'b0, ar_ready_i = 1'b0;
    logic [SW-1:0] ar_sel_i = 3'd0;
    logic          b_done_i = 1'b0, r_done_i = 1'b0;
    logic [SW-1:0] b_sel_i = 3'd0, r_sel_i = 3'd0;
    logic          drain_req_i = 1'b0;
    logic          aw_ready_o, aw_valid_o, ar_ready_o, ar_valid_o;
    logic          drain_ack_o, busy_o, err_o;

    int checks = 0;
    int errors = 0;

    cluster_noc_txn_throttle #(.NumClusters(NC), .MaxTxns(MT)) dut (
        .clk_i(clk), .rst_i(rst),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_sel_i(aw_sel_i),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_sel_i(ar_sel_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .b_done_i(b_done_i), .b_sel_i(b_sel_i),
        .r_done_i(r_done_i), .r_sel_i(r_sel_i),
        .drain_req_i(drain_req_i), .drain_ack_o(drain_ack_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_aw(input logic [SW-1:0] sel);
        aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_sel_i = sel;
        #1;
        checks++; if (aw_valid_o !== 1'b1) begin errors++; $display("FAIL issue_aw_valid sel=%0d: got %b want 1", sel, aw_valid_o); end
        tick();
        aw_valid_i = 1'b0; aw_ready_i = 1'b0;
    endtask

    task automatic issue_ar(input logic [SW-1:0] sel);
        ar_valid_i = 1'b1; ar_ready_i = 1'b1; ar_sel_i = sel;
        #1;
        checks++; if (ar_valid_o !== 1'b1) begin errors++; $display("FAIL issue_ar_valid sel=%0d: got %b want 1", sel, ar_valid_o); end
        tick();
        ar_valid_i = 1'b0; ar_ready_i = 1'b0;
    endtask

    task automatic pulse_b(input logic [SW-1:0] sel);
        b_done_i = 1'b1; b_sel_i = sel;
        tick();
        b_done_i = 1'b0;
    endtask

    task automatic pulse_r(input logic [SW-1:0] sel);
        r_done_i = 1'b1; r_sel_i = sel;
        tick();
        r_done_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
        checks++; if (drain_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", drain_ack_o); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_sel_i = 3'd1;
        #1;
        checks++; if (aw_valid_o !== 1'b1) begin errors++; $display("FAIL bp_first: got %b want 1", aw_valid_o); end
        tick();
        checks++; if (aw_valid_o !== 1'b1) begin errors++; $display("FAIL bp_second: got %b want 1", aw_valid_o); end
        tick();
        checks++; if (aw_valid_o !== 1'b0) begin errors++; $display("FAIL bp_third_valid: got %b want 0", aw_valid_o); end
        checks++; if (aw_ready_o !== 1'b0) begin errors++; $display("FAIL bp_third_ready: got %b want 0", aw_ready_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b want 1", busy_o); end
        tick();
        b_done_i = 1'b1; b_sel_i = 3'd1;
        #1;
        checks++; if (aw_valid_o !== 1'b0) begin errors++; $display("FAIL bp_hold_during_b: got %b want 0", aw_valid_o); end
        tick();
        b_done_i = 1'b0;
        #1;
        checks++; if (aw_valid_o !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", aw_valid_o); end
        tick();
        aw_valid_i = 1'b0; aw_ready_i = 1'b0;
        pulse_b(3'd1);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL bp_busy_one_left: got %b want 1", busy_o); end
        pulse_b(3'd1);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL bp_busy_clear: got %b want 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL bp_err: got %b want 0", err_o); end
    endtask

    task automatic test_same_cycle();
        issue_aw(3'd0);
        aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_sel_i = 3'd0;
        b_done_i = 1'b1; b_sel_i = 3'd0;
        #1;
        checks++; if (aw_valid_o !== 1'b1) begin errors++; $display("FAIL same_valid: got %b want 1", aw_valid_o); end
        tick();
        aw_valid_i = 1'b0; aw_ready_i = 1'b0; b_done_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL same_busy: got %b want 1", busy_o); end
        issue_aw(3'd0);
        aw_valid_i = 1'b1; aw_sel_i = 3'd0;
        #1;
        checks++; if (aw_valid_o !== 1'b0) begin errors++; $display("FAIL same_full: got %b want 0", aw_valid_o); end
        aw_valid_i = 1'b0;
        pulse_b(3'd0);
        pulse_b(3'd0);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL same_busy_clear: got %b want 0", busy_o); end
        // Different ports in one cycle: issue to 2 while completing 1.
        issue_aw(3'd1);
        aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_sel_i = 3'd2;
        b_done_i = 1'b1; b_sel_i = 3'd1;
        tick();
        aw_valid_i = 1'b0; aw_ready_i = 1'b0; b_done_i = 1'b0;
        pulse_b(3'd2);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL diff_busy: got %b want 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL diff_err: got %b want 0", err_o); end
    endtask

    task automatic test_drain();
        issue_ar(3'd3);
        issue_ar(3'd3);
        drain_req_i = 1'b1;
        tick();
        ar_valid_i = 1'b1; ar_ready_i = 1'b0; ar_sel_i = 3'd0;
        #1;
        checks++; if (ar_valid_o !== 1'b0) begin errors++; $display("FAIL drain_ar_blocked: got %b want 0", ar_valid_o); end
        checks++; if (drain_ack_o !== 1'b0) begin errors++; $display("FAIL drain_ack_early: got %b want 0", drain_ack_o); end
        pulse_r(3'd3);
        checks++; if (drain_ack_o !== 1'b0) begin errors++; $display("FAIL drain_ack_one_left: got %b want 0", drain_ack_o); end
        pulse_r(3'd3);
        checks++; if (drain_ack_o !== 1'b1) begin errors++; $display("FAIL drain_ack: got %b want 1", drain_ack_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL drain_busy: got %b want 0", busy_o); end
        checks++; if (ar_valid_o !== 1'b0) begin errors++; $display("FAIL idle_ar_blocked: got %b want 0", ar_valid_o); end
        drain_req_i = 1'b0;
        tick();
        checks++; if (drain_ack_o !== 1'b0) begin errors++; $display("FAIL run_ack: got %b want 0", drain_ack_o); end
        checks++; if (ar_valid_o !== 1'b1) begin errors++; $display("FAIL run_ar_open: got %b want 1", ar_valid_o); end
        ar_valid_i = 1'b0;
        // Drain request withdrawn while a write is still outstanding.
        issue_aw(3'd0);
        drain_req_i = 1'b1;
        tick();
        aw_valid_i = 1'b1; aw_ready_i = 1'b0; aw_sel_i = 3'd4;
        #1;
        checks++; if (aw_valid_o !== 1'b0) begin errors++; $display("FAIL abort_blocked: got %b want 0", aw_valid_o); end
        drain_req_i = 1'b0;
        tick();
        checks++; if (aw_valid_o !== 1'b1) begin errors++; $display("FAIL abort_run: got %b want 1", aw_valid_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b want 1", busy_o); end
        aw_valid_i = 1'b0;
        pulse_b(3'd0);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy_clear: got %b want 0", busy_o); end
    endtask

    task automatic test_error_slave();
        issue_aw(3'd4);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL errslv_busy: got %b want 1", busy_o); end
        pulse_b(3'd4);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL errslv_busy_clear: got %b want 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL errslv_err: got %b want 0", err_o); end
        aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_sel_i = 3'd5;
        #1;
        checks++; if (aw_valid_o !== 1'b0) begin errors++; $display("FAIL oob_valid: got %b want 0", aw_valid_o); end
        checks++; if (aw_ready_o !== 1'b0) begin errors++; $display("FAIL oob_ready: got %b want 0", aw_ready_o); end
        tick();
        aw_valid_i = 1'b0; aw_ready_i = 1'b0;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL oob_err: got %b want 1", err_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL oob_busy: got %b want 0", busy_o); end
        tick();
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL oob_err_sticky: got %b want 1", err_o); end
    endtask

    task automatic test_reset_midflight();
        issue_aw(3'd0);
        issue_aw(3'd2);
        issue_ar(3'd1);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy_o); end
        aw_ready_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b want 0", err_o); end
        checks++; if (drain_ack_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ack: got %b want 0", drain_ack_o); end
        checks++; if (aw_ready_o !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", aw_ready_o); end
        aw_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_underflow();
        pulse_b(3'd2);
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL uflow_err: got %b want 1", err_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL uflow_busy: got %b want 0", busy_o); end
        tick();
        tick();
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL uflow_sticky: got %b want 1", err_o); end
        // A port-2 issue after underflow must leave a count of exactly 1.
        issue_aw(3'd2);
        pulse_b(3'd2);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL uflow_count: got %b want 0", busy_o); end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_same_cycle();
        test_drain();
        test_error_slave();
        test_reset_midflight();
        test_underflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cluster_noc_txn_throttle.md
CLUSTER_NOC_TXN_THROTTLE -- requirements
Module: cluster_noc_txn_throttle

Interface
REQ-001 SHALL have parameter NumClusters, default 4: number of cluster ports; port index NumClusters is the decode-error slave.
REQ-002 SHALL have parameter MaxTxns, default 8: maximum outstanding transactions per port per direction, range 1..255.
REQ-003 SHALL have derived parameter SelWidth = idx_width(NumClusters+1), not overridable.
REQ-004 SHALL have derived parameter CntWidth = $clog2(MaxTxns+1), not overridable.
REQ-005 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  reset, asynchronous and active-high.
REQ-007 aw_valid_i  in  1  upstream AW valid.
REQ-008 aw_ready_o  out  1  upstream AW ready.
REQ-009 aw_sel_i  in  SelWidth  target port of the AW beat.
REQ-010 aw_valid_o  out  1  downstream AW valid, toward the demux.
REQ-011 aw_ready_i  in  1  downstream AW ready.
REQ-012 ar_valid_i, ar_ready_o, ar_sel_i, ar_valid_o, ar_ready_i: same as REQ-007..011, read address channel.
REQ-013 b_done_i  in  1  B handshake completed (valid&ready) at the upstream side.
REQ-014 b_sel_i  in  SelWidth  port that returned the B.
REQ-015 r_done_i  in  1  R handshake with last=1 completed.
REQ-016 r_sel_i  in  SelWidth  port that returned the last R beat.
REQ-017 drain_req_i  in  1  level request to quiesce traffic.
REQ-018 drain_ack_o  out  1  high while quiesced.
REQ-019 busy_o  out  1  any counter nonzero.
REQ-020 err_o  out  1  sticky underflow or out-of-range select flag.

Function
REQ-021 SHALL keep per port p (0..NumClusters) two CntWidth counters: wcnt[p] and rcnt[p].
REQ-022 aw_block SHALL equal (wcnt[aw_sel_i]==MaxTxns) | (state!=RUN) | (aw_sel_i>NumClusters).
REQ-023 aw_valid_o SHALL equal aw_valid_i & ~aw_block; aw_ready_o SHALL equal aw_ready_i & ~aw_block; both purely combinational, zero latency.
REQ-024 AR gating SHALL mirror REQ-022/023 using rcnt and ar_sel_i.
REQ-025 Issue = aw_valid_o & aw_ready_i: wcnt[aw_sel_i] +1 next cycle.
REQ-026 b_done_i SHALL decrement wcnt[b_sel_i] by 1 next cycle.
REQ-027 Issue and completion on the same port in the same cycle: counter SHALL be unchanged.
REQ-028 Issue and completion on different ports in the same cycle: both counters SHALL update.
REQ-029 Completion while the counter is 0: counter SHALL stay 0 and err_o SHALL set.
REQ-030 Select > NumClusters on any input with its valid/done asserted: err_o SHALL set, no counter changes, address beat blocked.
REQ-031 err_o SHALL clear only on reset.
REQ-032 Counters SHALL never exceed MaxTxns; no wrap-around.
REQ-033 Read counters SHALL follow REQ-025..029 using ar/r signals.
REQ-034 FSM states SHALL be RUN, DRAIN, IDLE.
REQ-035 RUN->DRAIN when drain_req_i=1.
REQ-036 DRAIN->IDLE when all counters are 0, including completions arriving in that same cycle.
REQ-037 IDLE->RUN when drain_req_i=0.
REQ-038 DRAIN->RUN when drain_req_i drops before empty.
REQ-039 drain_ack_o SHALL be 1 only in IDLE, registered.
REQ-040 In DRAIN and IDLE, no new AW/AR SHALL be issued; completions SHALL still be counted.
REQ-041 A beat already presented with valid high when blocking begins is dropped from downstream valid; upstream sees no ready and holds it (AXI-legal).
REQ-042 busy_o SHALL be the registered OR of all counters nonzero.

Reset
REQ-043 rst_i asserted SHALL immediately force: counters 0, state RUN, drain_ack_o 0, busy_o 0, err_o 0.
REQ-044 Reset mid-transaction SHALL discard all counts; the system resets the NoC concurrently.
REQ-045 First counting edge SHALL be the first rising clk_i after rst_i deasserts.

Verification
REQ-046 MaxTxns=2: 3 back-to-back AWs to port 1 with aw_ready_i=1 -> first two pass; third has aw_valid_o=0 and aw_ready_o=0 until a B with b_sel_i=1, then it issues next cycle.
REQ-047 wcnt[0]=1, then AW issue and b_done_i both on port 0 in the same cycle -> wcnt[0] stays 1; busy_o stays 1.
REQ-048 2 reads outstanding to port 3, drain_req_i=1 -> state DRAIN, ar_valid_o=0; after the 2nd r_done_i, drain_ack_o=1 one cycle later; drain_req_i=0 -> RUN, drain_ack_o=0.
REQ-049 b_done_i with b_sel_i=2 while wcnt[2]=0 -> err_o=1 and held; wcnt[2]=0.
REQ-050 AW to port NumClusters (error slave) -> counted like any other port; aw_sel_i=NumClusters+1 (when representable) -> blocked, err_o=1.
REQ-051 rst_i pulsed with 3 transactions outstanding -> all outputs at reset values asynchronously; busy_o=0.
